// File: rtl/ns3_readout_pkg.sv
// Shared types and default sizes for the sample readout controller.
// Optional feature macro: MINMAX_PAIR_EN (min/max pair tagging).
package ns3_readout_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    FINISH
  } state_t;

endpackage

// File: rtl/readout_addr_gen.sv
// Wrapping read-address counter with a remaining-sample down-counter.
// Optional feature macro: none (see sample_readout_ctrl for MINMAX_PAIR_EN).
module readout_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] addr,
  output logic              zero,
  output logic              last
);

  logic [ADDR_W:0] rem;

  // Address wraps naturally at 2^ADDR_W through truncation.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= start_addr;
      rem  <= length;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      rem  <= rem - (ADDR_W+1)'(1);
    end
  end

  assign zero = (rem == '0);
  assign last = (rem == (ADDR_W+1)'(1));

endmodule

// File: rtl/sample_readout_ctrl.sv
// Sample-memory readout FSM with valid/ready host handshake.
// Optional feature macro: MINMAX_PAIR_EN (min/max pair tagging).
module sample_readout_ctrl
  import ns3_readout_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START_RD,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [ADDR_W:0]   LENGTH,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_RD_EN,
  input  logic [DATA_W-1:0] RAM_DATA,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              MIN_MAX_SEL
);

  state_t state;
  state_t state_nx;

  logic              load;
  logic              step;
  logic              zero;
  logic              last;
  logic [ADDR_W:0]   len_eff;
  logic [DATA_W-1:0] data_q;

  readout_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (CLK),
    .rst       (RST),
    .load      (load),
    .step      (step),
    .start_addr(START_ADDR),
    .length    (len_eff),
    .addr      (RAM_ADDR),
    .zero      (zero),
    .last      (last)
  );

`ifdef MINMAX_PAIR_EN
  logic acc_odd;
  logic sel_q;

  // Odd lengths get one extra sample so min/max always come in pairs.
  assign len_eff = LENGTH + (ADDR_W+1)'(LENGTH[0]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_odd <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      if (load)
        acc_odd <= 1'b0;
      else if (step)
        acc_odd <= ~acc_odd;
      if (state == WAIT)
        sel_q <= acc_odd;
    end
  end

  assign MIN_MAX_SEL = sel_q;
`else
  assign len_eff     = LENGTH;
  assign MIN_MAX_SEL = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      data_q <= '0;
    else if (state == WAIT)
      data_q <= RAM_DATA;
  end

  assign DATA_OUT = data_q;

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    step       = 1'b0;
    RAM_RD_EN  = 1'b0;
    DATA_VALID = 1'b0;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    unique case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START_RD) begin
          load     = 1'b1;
          state_nx = (len_eff == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        RAM_RD_EN = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        state_nx = HOLD;
      end
      HOLD: begin
        DATA_VALID = 1'b1;
        if (DATA_READY) begin
          step     = 1'b1;
          state_nx = (last || zero) ? FINISH : FETCH;
        end
      end
      FINISH: begin
        DONE     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
